// File: rtl/tt_pkg.sv
// Shared types and sizing helpers for the tt_capture truth-table extractor.
package tt_pkg;

  localparam int NUM_INPUTS_DEF = 7;
  localparam int SETTLE_W       = 4;

  function automatic int tt_w(input int n);
    return 1 << n;
  endfunction

  function automatic int ones_w(input int n);
    return n + 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    SAMPLE,
    DONE
  } state_e;

endpackage

// File: rtl/tt_capture_pattern_gen.sv
// tt_pattern_gen: input-pattern index counter and settle timer for tt_capture.
module tt_pattern_gen
  import tt_pkg::*;
#(
  parameter int NUM_INPUTS    = NUM_INPUTS_DEF,
  parameter int SETTLE_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_hold,
  input  logic                  i_advance,
  output logic [NUM_INPUTS-1:0] o_x_out,
  output logic                  o_sample,
  output logic                  o_last
);

  localparam logic [NUM_INPUTS-1:0] IDX_LAST    = '1;
  localparam logic [SETTLE_W-1:0]   SETTLE_LAST =
    SETTLE_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  logic [NUM_INPUTS-1:0] r_idx;
  logic [SETTLE_W-1:0]   r_settle;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx    <= '0;
      r_settle <= '0;
    end else if (i_start) begin
      r_idx    <= '0;
      r_settle <= '0;
    end else if (i_advance) begin
      r_idx    <= r_idx + NUM_INPUTS'(1);
      r_settle <= '0;
    end else if (i_hold) begin
      r_settle <= r_settle + SETTLE_W'(1);
    end
  end

  assign o_x_out  = r_idx;
  assign o_last   = (r_idx == IDX_LAST);
  // Settle expiry: the HOLD cycle whose edge hands over to SAMPLE.
  assign o_sample = i_hold && (r_settle == SETTLE_LAST);

endmodule

// File: rtl/tt_capture.sv
// tt_capture: scans all 2**NUM_INPUTS patterns and packs f_in into a truth table.
// Optional macro TT_CAPTURE_COMPARE_EN adds exp_tt / tt_match expectation check.
module tt_capture
  import tt_pkg::*;
#(
  parameter  int NUM_INPUTS    = NUM_INPUTS_DEF,
  parameter  int SETTLE_CYCLES = 0,
  localparam int TT_W          = tt_w(NUM_INPUTS),
  localparam int ONES_W        = ones_w(NUM_INPUTS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [NUM_INPUTS-1:0] x_out,
  input  logic                  f_in,
  output logic                  busy,
  output logic                  tt_valid,
  input  logic                  tt_ready,
  output logic [TT_W-1:0]       tt_data,
  output logic [ONES_W-1:0]     tt_ones
`ifdef TT_CAPTURE_COMPARE_EN
  ,
  input  logic [TT_W-1:0]       exp_tt,
  output logic                  tt_match
`endif
);

  state_e              r_state;
  logic                r_busy;
  logic                r_tt_valid;
  logic [TT_W-1:0]     r_tt_data;
  logic [ONES_W-1:0]   r_tt_ones;
`ifdef TT_CAPTURE_COMPARE_EN
  logic [TT_W-1:0]     r_exp_tt;
  logic                r_mismatch;
  logic                r_tt_match;
`endif

  logic                  w_start_acc;
  logic                  w_hold;
  logic                  w_advance;
  logic                  w_sample;
  logic                  w_last;
  logic [NUM_INPUTS-1:0] w_x;

  assign w_start_acc = (r_state == IDLE) && start;
  assign w_hold      = (r_state == HOLD);
  assign w_advance   = (r_state == SAMPLE) && !w_last;

  tt_pattern_gen #(
    .NUM_INPUTS    (NUM_INPUTS),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_pattern_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_start_acc),
    .i_hold    (w_hold),
    .i_advance (w_advance),
    .o_x_out   (w_x),
    .o_sample  (w_sample),
    .o_last    (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_tt_valid <= 1'b0;
      r_tt_data  <= '0;
      r_tt_ones  <= '0;
`ifdef TT_CAPTURE_COMPARE_EN
      r_exp_tt   <= '0;
      r_mismatch <= 1'b0;
      r_tt_match <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_busy    <= 1'b1;
            r_tt_data <= '0;
            r_tt_ones <= '0;
`ifdef TT_CAPTURE_COMPARE_EN
            r_exp_tt   <= exp_tt;
            r_mismatch <= 1'b0;
            r_tt_match <= 1'b0;
`endif
            if (SETTLE_CYCLES == 0) r_state <= SAMPLE;
            else                    r_state <= HOLD;
          end
        end
        HOLD: begin
          if (w_sample) r_state <= SAMPLE;
        end
        SAMPLE: begin
          // Pattern index doubles as the truth-table bit position.
          r_tt_data[w_x] <= f_in;
          r_tt_ones      <= r_tt_ones + ONES_W'(f_in);
`ifdef TT_CAPTURE_COMPARE_EN
          r_mismatch <= r_mismatch | (f_in ^ r_exp_tt[w_x]);
`endif
          if (w_last) begin
            r_state    <= DONE;
            r_tt_valid <= 1'b1;
`ifdef TT_CAPTURE_COMPARE_EN
            r_tt_match <= !(r_mismatch | (f_in ^ r_exp_tt[w_x]));
`endif
          end else if (SETTLE_CYCLES == 0) begin
            r_state <= SAMPLE;
          end else begin
            r_state <= HOLD;
          end
        end
        DONE: begin
          if (tt_ready) begin
            r_state    <= IDLE;
            r_tt_valid <= 1'b0;
            r_busy     <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign x_out    = w_x;
  assign busy     = r_busy;
  assign tt_valid = r_tt_valid;
  assign tt_data  = r_tt_data;
  assign tt_ones  = r_tt_ones;
`ifdef TT_CAPTURE_COMPARE_EN
  assign tt_match = r_tt_match;
`endif

endmodule

// File: tb/tb_tt_capture.sv
// Directed bench for tt_capture: model functions, settle timing, handshake, reset.
module tb_tt_capture;

  typedef enum int {F_X0, F_MAJ, F_AND, F_ZERO, F_TABLE} mode_e;

  localparam int          BUDGET = 1000;
  localparam logic [127:0] TT_X0  = 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA;
  localparam logic [127:0] TT_MAJ = {16{8'hE8}};
  localparam logic [127:0] TT_AND = 128'h1 << 127;
  localparam logic [127:0] TT_EXP = 128'hfeeefaa8fee0e880fee8f880eaa08880;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, tt_ready;
  logic [6:0]   x_out;
  logic         f_in, busy, tt_valid;
  logic [127:0] tt_data;
  logic [7:0]   tt_ones;

  logic         start3, tt_ready3;
  logic [6:0]   x_out3;
  logic         f_in3, busy3, tt_valid3;
  logic [127:0] tt_data3;
  logic [7:0]   tt_ones3;

`ifdef TT_CAPTURE_COMPARE_EN
  logic [127:0] exp_tt;
  logic         tt_match, tt_match3;
`endif

  mode_e        mode;
  logic         delay_en;
  logic [127:0] tbl;
  logic [6:0]   d1 = '0, d2 = '0, d3 = '0;
  logic [6:0]   e1 = '0, e2 = '0, e3 = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  function automatic logic f_model(input mode_e m, input logic [6:0] x, input logic [127:0] t);
    case (m)
      F_X0:    return x[0];
      F_MAJ:   return (x[0] & x[1]) | (x[0] & x[2]) | (x[1] & x[2]);
      F_AND:   return &x;
      F_TABLE: return t[x];
      default: return 1'b0;
    endcase
  endfunction

  // Function-under-test with an optional three-cycle output delay.
  always @(posedge clk) begin
    d1 <= x_out;  d2 <= d1; d3 <= d2;
    e1 <= x_out3; e2 <= e1; e3 <= e2;
  end
  assign f_in  = f_model(mode, delay_en ? d3 : x_out, tbl);
  assign f_in3 = e3[0];

  tt_capture #(.NUM_INPUTS(7), .SETTLE_CYCLES(0)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .x_out    (x_out),
    .f_in     (f_in),
    .busy     (busy),
    .tt_valid (tt_valid),
    .tt_ready (tt_ready),
    .tt_data  (tt_data),
    .tt_ones  (tt_ones)
`ifdef TT_CAPTURE_COMPARE_EN
    ,
    .exp_tt   (exp_tt),
    .tt_match (tt_match)
`endif
  );

  tt_capture #(.NUM_INPUTS(7), .SETTLE_CYCLES(3)) u_dut3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start3),
    .x_out    (x_out3),
    .f_in     (f_in3),
    .busy     (busy3),
    .tt_valid (tt_valid3),
    .tt_ready (tt_ready3),
    .tt_data  (tt_data3),
    .tt_ones  (tt_ones3)
`ifdef TT_CAPTURE_COMPARE_EN
    ,
    .exp_tt   (128'h0),
    .tt_match (tt_match3)
`endif
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_differs(input string tag, input logic [127:0] obs, input logic [127:0] avoid);
    n_tests++;
    assert (obs !== avoid) else begin
      n_fail++;
      $error("FAIL %s: observed %h must differ from %h", tag, obs, avoid);
    end
  endtask

  task automatic run_scan(output int edges);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    edges = 0;
    for (int i = 0; i < BUDGET; i++) begin
      @(posedge clk); #1;
      edges++;
      if (tt_valid) break;
    end
  endtask

  task automatic handshake(input string tag);
    @(negedge clk); tt_ready = 1'b1;
    @(posedge clk); #1;
    check(tag, 128'(busy), 128'(0));
    @(negedge clk); tt_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int           edges;
    logic         stable;
    start = 0; tt_ready = 0; start3 = 0; tt_ready3 = 0;
    mode = F_X0; delay_en = 0; tbl = '0;
`ifdef TT_CAPTURE_COMPARE_EN
    exp_tt = '0;
`endif
    rst_n = 1'b0;
    #1;
    check("rst_busy",  128'(busy),     128'(0));
    check("rst_valid", 128'(tt_valid), 128'(0));
    check("rst_x",     128'(x_out),    128'(0));
    check("rst_data",  tt_data,        128'(0));
    check("rst_ones",  128'(tt_ones),  128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // f = x0
    run_scan(edges);
    check("x0_latency", 128'(edges),   128'(128));
    check("x0_data",    tt_data,       TT_X0);
    check("x0_ones",    128'(tt_ones), 128'(64));
    check("x0_x_hold",  128'(x_out),   128'(7'h7f));

    // Stall 20 cycles with a start pulse in the middle
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); start = (i == 5);
      @(posedge clk); #1;
      if (tt_data !== TT_X0 || tt_ones !== 8'd64 || !busy || !tt_valid) stable = 1'b0;
    end
    start = 1'b0;
    check("stall_stable", 128'(stable),   128'(1));
    check("stall_x_hold", 128'(x_out),    128'(7'h7f));

    // Handshake edge with start also high: start must be ignored
    @(negedge clk); tt_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    check("hs_busy",  128'(busy),     128'(0));
    check("hs_valid", 128'(tt_valid), 128'(0));
    check("hs_x",     128'(x_out),    128'(7'h7f));
    @(negedge clk); tt_ready = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check("hs_start_ignored", 128'(busy), 128'(0));

    // f = maj(x0,x1,x2)
    mode = F_MAJ;
    run_scan(edges);
    check("maj_latency", 128'(edges),   128'(128));
    check("maj_data",    tt_data,       TT_MAJ);
    check("maj_ones",    128'(tt_ones), 128'(64));
    handshake("maj_hs");

    // f = AND of all, tt_ready already high on arrival
    mode = F_AND;
    tt_ready = 1'b1;
    run_scan(edges);
    check("and_latency", 128'(edges),   128'(128));
    check("and_data",    tt_data,       TT_AND);
    check("and_ones",    128'(tt_ones), 128'(1));
    @(posedge clk); #1;
    check("and_fast_hs_valid", 128'(tt_valid), 128'(0));
    check("and_fast_hs_busy",  128'(busy),     128'(0));
    tt_ready = 1'b0;

    // f = 0
    mode = F_ZERO;
    run_scan(edges);
    check("zero_data", tt_data,       128'(0));
    check("zero_ones", 128'(tt_ones), 128'(0));
    handshake("zero_hs");

    // Delayed model without settle time samples stale outputs
    mode = F_X0; delay_en = 1'b1;
    run_scan(edges);
    check_differs("nosettle_data", tt_data, TT_X0);
    handshake("nosettle_hs");
    delay_en = 1'b0;

    // Delayed model with SETTLE_CYCLES=3
    @(negedge clk); start3 = 1'b1;
    @(posedge clk); #1; start3 = 1'b0;
    edges = 0;
    for (int i = 0; i < 4 * BUDGET; i++) begin
      @(posedge clk); #1;
      edges++;
      if (tt_valid3) break;
    end
    check("settle3_latency", 128'(edges),    128'(512));
    check("settle3_data",    tt_data3,       TT_X0);
    check("settle3_ones",    128'(tt_ones3), 128'(64));
    @(negedge clk); tt_ready3 = 1'b1;
    @(posedge clk); #1;
    check("settle3_hs_busy", 128'(busy3), 128'(0));
    @(negedge clk); tt_ready3 = 1'b0;

    // Asynchronous reset in the middle of a scan
    mode = F_X0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    edges = 0;
    for (int i = 0; i < BUDGET; i++) begin
      @(posedge clk); #1;
      edges++;
      if (x_out == 7'd60) break;
    end
    check("arst_reached_60", 128'(edges), 128'(60));
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 128'(busy),    128'(0));
    check("arst_x",    128'(x_out),   128'(0));
    check("arst_data", tt_data,       128'(0));
    check("arst_ones", 128'(tt_ones), 128'(0));
    @(negedge clk); rst_n = 1'b1;
    mode = F_MAJ;
    run_scan(edges);
    check("post_rst_latency", 128'(edges),   128'(128));
    check("post_rst_data",    tt_data,       TT_MAJ);
    check("post_rst_ones",    128'(tt_ones), 128'(64));
    handshake("post_rst_hs");

`ifdef TT_CAPTURE_COMPARE_EN
    mode = F_TABLE; tbl = TT_EXP; exp_tt = TT_EXP;
    run_scan(edges);
    check("cmp_data",  tt_data,        TT_EXP);
    check("cmp_match", 128'(tt_match), 128'(1));
    handshake("cmp_hs");
    tbl = TT_EXP ^ (128'h1 << 37);
    run_scan(edges);
    check("cmp_flip_match", 128'(tt_match), 128'(0));
    handshake("cmp_flip_hs");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
